// File: rtl/dlx_pkg.sv
// Shared DLX definitions: jump-type encodings, fetch defaults and the fetch FSM states.
package dlx_pkg;

  typedef enum logic [1:0] {
    JT_REG   = 2'b00,
    JT_IMM16 = 2'b01,
    JT_IMM26 = 2'b10,
    JT_IAR   = 2'b11
  } jump_type_e;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD     = 32'h0000_0000;

  // Fetch addresses are always word aligned; low target bits are simply dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dlx_branch_target.sv
// Combinational taken/target resolution for control transfers sitting in EX.
module dlx_branch_target
  import dlx_pkg::*;
(
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [1:0]  ex_jump_type_i,
  input  logic        ex_cond_src_i,
  input  logic        ex_branch_cond_i,
  input  logic        ex_alu_zero_i,
  input  logic        ex_fpsr_i,
  input  logic [31:0] ex_pc4_i,
  input  logic [25:0] ex_imm26_i,
  input  logic [31:0] ex_reg_a_i,
  input  logic [31:0] iar_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic cond;

  always_comb begin
    cond    = ex_cond_src_i ? ex_alu_zero_i : ex_fpsr_i;
    taken_o = ex_valid_i & (ex_is_branch_i ? (cond == ex_branch_cond_i) : 1'b1);
    case (jump_type_e'(ex_jump_type_i))
      JT_IMM16: target_o = ex_pc4_i + {{16{ex_imm26_i[15]}}, ex_imm26_i[15:0]};
      JT_IMM26: target_o = ex_pc4_i + {{6{ex_imm26_i[25]}}, ex_imm26_i};
      JT_IAR:   target_o = iar_i;
      default:  target_o = ex_reg_a_i;
    endcase
  end

endmodule

// File: rtl/dlx_ifetch.sv
// DLX instruction fetch: PC, imem handshake, one-entry skid buffer and the IF/ID register.
// Define DLX_IFETCH_DELAY_SLOT_EN to keep the IF/ID entry (delay slot) across a redirect.
module dlx_ifetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_WORD     = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [1:0]  ex_jump_type,
  input  logic        ex_cond_src,
  input  logic        ex_branch_cond,
  input  logic        ex_alu_zero,
  input  logic        ex_fpsr,
  input  logic [31:0] ex_pc4,
  input  logic [25:0] ex_imm26,
  input  logic [31:0] ex_reg_a,
  input  logic [31:0] iar,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Function
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, disc_addr_q, disc_addr_d;
  logic         run_q;
  logic         hold_full_q, hold_full_d;
  logic [31:0]  hold_instr_q, hold_instr_d, hold_pc4_q, hold_pc4_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         taken, accept;
  logic [31:0]  target, pc_plus4;

  dlx_branch_target u_target (
    .ex_valid_i      (ex_valid),
    .ex_is_branch_i  (ex_is_branch),
    .ex_jump_type_i  (ex_jump_type),
    .ex_cond_src_i   (ex_cond_src),
    .ex_branch_cond_i(ex_branch_cond),
    .ex_alu_zero_i   (ex_alu_zero),
    .ex_fpsr_i       (ex_fpsr),
    .ex_pc4_i        (ex_pc4),
    .ex_imm26_i      (ex_imm26),
    .ex_reg_a_i      (ex_reg_a),
    .iar_i           (iar),
    .taken_o         (taken),
    .target_o        (target)
  );

  // DISCARD keeps presenting the abandoned address until memory completes it.
  assign imem_req  = run_q & ((state_q == DISCARD) | ~hold_full_q);
  assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign accept    = imem_req & imem_ready & (state_q == FETCH);
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    hold_full_d  = hold_full_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (taken) begin
      pc_d        = word_align(target);
      hold_full_d = 1'b0;
      if ((state_q == FETCH) && imem_req && !imem_ready) begin
        state_d     = DISCARD;
        disc_addr_d = pc_q;
      end
    end else if (accept) begin
      pc_d = pc_plus4;
    end
    if ((state_q == DISCARD) && imem_ready) begin
      state_d = FETCH;
    end

    // A redirect squashes the buffered and in-flight words before stall is considered.
    if (taken) begin
`ifdef DLX_IFETCH_DELAY_SLOT_EN
      if (!stall) begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end
`else
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
`endif
    end else if (!stall) begin
      if (hold_full_q) begin
        ifid_instr_d = hold_instr_q;
        ifid_pc4_d   = hold_pc4_q;
        ifid_valid_d = 1'b1;
        hold_full_d  = 1'b0;
      end else if (accept) begin
        ifid_instr_d = imem_rdata;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end
    end else if (accept) begin
      hold_full_d  = 1'b1;
      hold_instr_d = imem_rdata;
      hold_pc4_d   = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= word_align(RESET_VECTOR);
      disc_addr_q  <= 32'd0;
      run_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_instr_q <= NOP_WORD;
      hold_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      run_q        <= 1'b1;
      hold_full_q  <= hold_full_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // DLX numbers bits MSB-first, so OpCode [0:5] is [31:26] and Function [26:31] is [5:0].
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign OpCode     = ifid_instr_q[31:26];
  assign Function   = ifid_instr_q[5:0];

endmodule

// File: doc/dlx_ifetch.md
Name: dlx_ifetch

Overview:
Instruction fetch stage of the DLX pipeline and the producer side of the control decoder.
- Owns the PC and runs a req/ready handshake to instruction memory.
- Buffers fetched words through a skid entry into the IF/ID register, which presents OpCode and Function slices to the decoder.
- Consumes the decoder's IFetch controls (JumpType, CondSrc, BranchCond), resolved in EX, to redirect the PC.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
NOP_WORD, 32'h0000_0000, IF/ID contents when invalid or flushed.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
imem_addr  out  32  fetch address, word aligned
imem_req  out  1  fetch request
imem_ready  in  1  memory accepts and returns data this cycle
imem_rdata  in  32  instruction word, valid when req&ready
stall  in  1  hazard unit: hold IF/ID
ex_valid  in  1  EX holds a control-transfer instruction
ex_is_branch  in  1  EX op is a conditional branch (opcodes 04-07)
ex_jump_type  in  2  00 reg, 01 imm16, 10 imm26, 11 IAR
ex_cond_src  in  1  0 FPSR, 1 ALU
ex_branch_cond  in  1  1 takes on true (BEQZ/BFPT), 0 takes on false
ex_alu_zero  in  1  ALU operand equals zero
ex_fpsr  in  1  FP status bit
ex_pc4  in  32  PC+4 of the EX instruction
ex_imm26  in  26  raw immediate field of the EX instruction
ex_reg_a  in  32  register target for JR/JALR
iar  in  32  interrupt address register, used by RFE
ifid_instr  out  32  IF/ID instruction
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a live instruction
OpCode  out  6  ifid_instr bits [0:5], bit 0 is the MSB
Function  out  6  ifid_instr bits [26:31]

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_VECTOR; state FETCH.
  - ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc4=0; hold buffer empty.
  - imem_req=0 during reset; 1 from the first cycle after release.
  - Reset mid-handshake abandons the transfer with no side effects.
- Handshake:
  - imem_addr must stay stable while req=1 && !ready.
  - A request is never withdrawn before ready.
  - imem_addr[30:31] is always 00; target low bits are truncated.
- Throughput:
  - With ready tied high and no stall, one instruction per cycle.
  - Latency from accept to ifid_valid is 1 cycle.
- Accept (req&ready in FETCH):
  - If !stall and the hold buffer is empty, the word goes to IF/ID.
  - If stall, the word goes to the hold buffer.
  - PC<=PC+4, wrapping mod 2^32.
- Hold buffer (1 entry):
  - While full, imem_req=0.
  - On the first !stall cycle, the buffer moves into IF/ID and empties.
- Stall with no new data: IF/ID holds its value.
- Taken condition:
  - cond = ex_cond_src ? ex_alu_zero : ex_fpsr.
  - taken = ex_valid & (ex_is_branch ? (cond==ex_branch_cond) : 1).
- Target (all sign extension, 32-bit wrap):
  - 00: ex_reg_a.
  - 01: ex_pc4 + sext(ex_imm26[10:25]).
  - 10: ex_pc4 + sext(ex_imm26).
  - 11: iar.
- Redirect (taken), which has priority over stall and accept:
  - PC<=target; hold buffer cleared.
  - IF/ID <= NOP_WORD, valid=0 (see the optional feature).
  - If a request is outstanding (req&!ready), go to DISCARD.
- FSM:
  - FETCH: normal operation.
  - DISCARD: req stays high at the old address. On ready, the data is dropped and the state returns to FETCH, requesting the new PC next cycle.
  - Redirect in DISCARD: update PC only; stay in DISCARD.
- Redirect in the same cycle as an accept: the accepted word is dropped; PC=target.

Optional Feature:
DLX_IFETCH_DELAY_SLOT_EN
- Defined: on redirect a valid IF/ID entry (the delay slot) is kept and obeys stall normally. The hold buffer and the in-flight fetch are still squashed.
- Undefined: IF/ID is flushed as described above.

Decomposition:
- Package dlx_pkg:
  - JumpType encodings JT_REG/JT_IMM16/JT_IMM26/JT_IAR.
  - NOP_WORD and RESET_VECTOR defaults.
  - Fetch FSM state typedef (FETCH, DISCARD).
- One sub-module, dlx_branch_target: combinational taken/target computation, reusable by a future branch predictor.

Test Plan:
- Reset release, ready=1, no stall → imem_addr 0,4,8; ifid_pc4 4,8,C one cycle after each accept; OpCode/Function match the returned words.
- Stall for 3 cycles after one accept → the next word sits in the hold buffer; req=0 while it is full; IF/ID unchanged; on release, IF/ID takes the buffered word with no fetch lost.
- BEQZ, ex_alu_zero=1, ex_pc4=0x100, imm16=0xFFF8 → next imem_addr 0xF8; IF/ID flushed (or kept with the macro).
- BFPF with ex_fpsr=1 → not taken; PC keeps incrementing. RFE (type 11, iar=0x2000) → imem_addr 0x2000.
- Redirect while req&!ready for 2 cycles at 0x40 → addr stays 0x40 until ready; that data is dropped; next request at the target.
- rst_n asserted mid-stall with a full buffer → all outputs return to reset values immediately (asynchronous).
